// File: rtl/fp_pkg.sv
// Shared constants and FSM state encoding for the single-precision divider.
package fp_pkg;
   localparam logic [9:0]  BIAS       = 10'd127;
   localparam logic [7:0]  EXP_MAX    = 8'hFF;
   localparam logic [31:0] QNAN       = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF    = 32'h7F80_0000;
   localparam logic [4:0]  MANT_STEPS = 5'd25;

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      NORM,
      DONE
   } state_t;
endpackage

// File: rtl/fp_divider_if.sv
// Request/result bundle between a divider client and the fp_divider core.
interface fp_divider_if;
   logic        start;
   logic [31:0] x;
   logic [31:0] y;
   logic        busy;
   logic        done;
   logic [31:0] q;
   logic        dz;

   modport master (output start, x, y, input busy, done, q, dz);
   modport slave  (input start, x, y, output busy, done, q, dz);
endinterface

// File: rtl/fp_mant_div.sv
// Restoring divide of {1,mx} by {1,my}: one quotient bit per step, MSB first.
module fp_mant_div
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic [22:0] mx,
   input  logic [22:0] my,
   output logic        ready,
   output logic [24:0] quo
);
   logic [24:0] rem;
   logic [23:0] dvs;
   logic [4:0]  cnt;
   logic [25:0] diff;
   logic        ge;
   logic [24:0] rem_sub;

   assign diff    = {1'b0, rem} - {2'b00, dvs};
   assign ge      = ~diff[25];
   assign rem_sub = ge ? diff[24:0] : rem;

   // cnt holds the steps remaining after the current one; ready marks the final step
   assign ready = (cnt == 5'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem <= '0;
         dvs <= '0;
         quo <= '0;
         cnt <= '0;
      end else if (load) begin
         rem <= {2'b01, mx};
         dvs <= {1'b1, my};
         quo <= '0;
         cnt <= MANT_STEPS - 5'd1;
      end else if (step) begin
         rem <= {rem_sub[23:0], 1'b0};
         quo <= {quo[23:0], ge};
         if (cnt != 5'd0)
            cnt <= cnt - 5'd1;
      end
   end
endmodule

// File: rtl/fp_divider.sv
// IEEE-754 single divider: truncating, denormals flushed, specials resolved in one cycle.
//  state  | meaning
//  IDLE   | wait for start, decode special operands
//  DIVIDE | one restoring mantissa step per cycle (25 cycles)
//  NORM   | normalize quotient, range-check exponent, load q
//  DONE   | one-cycle done pulse, q/dz valid
module fp_divider
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   fp_divider_if.slave bus
);
   state_t state, state_nxt;

   logic [7:0]        x_exp, y_exp;
   logic              x_zero, y_zero, sgn_in;
   logic              spec_hit, spec_dz;
   logic [31:0]       spec_q;
   logic              ld_spec, ld_norm, div_load, div_step, div_ready;
   logic [24:0]       quo;
   logic              sgn_r;
   logic [7:0]        ex_r, ey_r;
   logic [9:0]        exp_raw;
   logic signed [9:0] exp_s;
   logic [31:0]       norm_q;
   logic [31:0]       q_r;
   logic              dz_r;

   assign x_exp  = bus.x[30:23];
   assign y_exp  = bus.y[30:23];
   assign x_zero = (x_exp == 8'd0);
   assign y_zero = (y_exp == 8'd0);
   assign sgn_in = bus.x[31] ^ bus.y[31];

   always_comb begin
      spec_hit = 1'b1;
      spec_q   = QNAN;
      spec_dz  = 1'b0;
      if ((x_exp == EXP_MAX) || (y_exp == EXP_MAX)) begin
         spec_q = QNAN;
      end else if (x_zero && y_zero) begin
         spec_q = QNAN;
      end else if (y_zero) begin
         spec_q  = {sgn_in, POS_INF[30:0]};
         spec_dz = 1'b1;
      end else if (x_zero) begin
         spec_q = {sgn_in, 31'b0};
      end else begin
         spec_hit = 1'b0;
      end
   end

   fp_mant_div u_mant_div (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (div_load),
      .step  (div_step),
      .mx    (bus.x[22:0]),
      .my    (bus.y[22:0]),
      .ready (div_ready),
      .quo   (quo)
   );

   // Quotient lies in [0.5, 2): Q[24] selects the integer-bit position
   assign exp_raw = {2'b00, ex_r} - {2'b00, ey_r} + (quo[24] ? BIAS : (BIAS - 10'd1));
   assign exp_s   = exp_raw;

   always_comb begin
      if (exp_s >= 10'sd255)
         norm_q = {sgn_r, POS_INF[30:0]};
      else if (exp_s <= 10'sd0)
         norm_q = {sgn_r, 31'b0};
      else if (quo[24])
         norm_q = {sgn_r, exp_raw[7:0], quo[23:1]};
      else
         norm_q = {sgn_r, exp_raw[7:0], quo[22:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      div_load  = 1'b0;
      div_step  = 1'b0;
      ld_spec   = 1'b0;
      ld_norm   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (spec_hit) begin
                  ld_spec   = 1'b1;
                  state_nxt = DONE;
               end else begin
                  div_load  = 1'b1;
                  state_nxt = DIVIDE;
               end
            end
         end
         DIVIDE: begin
            div_step = 1'b1;
            if (div_ready)
               state_nxt = NORM;
         end
         NORM: begin
            ld_norm   = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sgn_r <= 1'b0;
         ex_r  <= 8'd0;
         ey_r  <= 8'd0;
         q_r   <= 32'd0;
         dz_r  <= 1'b0;
      end else begin
         if (div_load) begin
            sgn_r <= sgn_in;
            ex_r  <= x_exp;
            ey_r  <= y_exp;
         end
         if (ld_spec) begin
            q_r  <= spec_q;
            dz_r <= spec_dz;
         end else if (ld_norm) begin
            q_r  <= norm_q;
            dz_r <= 1'b0;
         end
      end
   end

   assign bus.busy = (state == DIVIDE) || (state == NORM);
   assign bus.done = (state == DONE);
   assign bus.q    = q_r;
   assign bus.dz   = dz_r;
endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: expected results queued at start, compared at done.
module tb_fp_divider;
   logic clk = 1'b0;
   logic rst_n;

   fp_divider_if bus ();

   fp_divider dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] q;
      logic        dz;
      int          lat;
      int          busy;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Drives one division from the current time (just after a rising edge).
   // lat counts rising edges from start being presented to done being seen.
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic edz, input int elat, input int poke_at);
      exp_t e;
      int   edges;
      int   busy_cyc;
      bit   seen;
      e.q    = eq;
      e.dz   = edz;
      e.lat  = elat;
      e.busy = (elat == 1) ? 0 : 26;
      sb.push_back(e);
      bus.x     = a;
      bus.y     = b;
      bus.start = 1'b1;
      edges     = 0;
      busy_cyc  = 0;
      seen      = 1'b0;
      while (!seen && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == 1) begin
            bus.start = 1'b0;
            bus.x     = $urandom;
            bus.y     = $urandom;
         end
         if (poke_at != 0 && edges == poke_at) begin
            bus.start = 1'b1;
            bus.x     = 32'h3F80_0000;
            bus.y     = 32'h4040_0000;
         end
         if (poke_at != 0 && edges == poke_at + 1)
            bus.start = 1'b0;
         if (bus.busy === 1'b1)
            busy_cyc++;
         if (bus.done === 1'b1)
            seen = 1'b1;
      end
      e = sb.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: no done after %0d edges, required %0d", name, edges, e.lat);
      end else begin
         if (bus.q !== e.q) begin
            errors++;
            $display("FAIL %s q: got %h required %h", name, bus.q, e.q);
         end
         checks++;
         if (bus.dz !== e.dz) begin
            errors++;
            $display("FAIL %s dz: got %b required %b", name, bus.dz, e.dz);
         end
         checks++;
         if (edges !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, edges, e.lat);
         end
         checks++;
         if (busy_cyc !== e.busy) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d required %0d", name, busy_cyc, e.busy);
         end
         @(posedge clk);
         #1;
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done pulse: done=%b busy=%b one cycle later, required 0 0",
                     name, bus.done, bus.busy);
         end
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.x     = 32'h40C0_0000;
      bus.y     = 32'h4080_0000;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.q !== 32'd0 || bus.dz !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs: busy=%b done=%b q=%h dz=%b required 0 0 00000000 0",
                  bus.busy, bus.done, bus.q, bus.dz);
      end
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset release idle: busy=%b done=%b required 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_normal();
      run_op("six_by_four", 32'h40C0_0000, 32'h4080_0000, 32'h3FC0_0000, 1'b0, 27, 0);
      run_op("one_by_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 27, 0);
      run_op("neg_six_by_four", 32'hC0C0_0000, 32'h4080_0000, 32'hBFC0_0000, 1'b0, 27, 0);
      run_op("three_by_neg_two", 32'h4040_0000, 32'hC000_0000, 32'hBFC0_0000, 1'b0, 27, 0);
      run_op("two_by_one", 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 27, 0);
   endtask

   task automatic test_special();
      run_op("neg_two_by_zero", 32'hC000_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1, 0);
      run_op("nan_operand", 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1, 0);
      run_op("inf_by_two", 32'hFF80_0000, 32'h4000_0000, 32'h7FC0_0000, 1'b0, 1, 0);
      run_op("zero_by_zero", 32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1, 0);
      run_op("zero_by_neg_three", 32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 1'b0, 1, 0);
      run_op("denorm_x_flushed", 32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 1'b0, 1, 0);
      run_op("denorm_y_flushed", 32'h3F80_0000, 32'h8040_0000, 32'hFF80_0000, 1'b1, 1, 0);
   endtask

   task automatic test_range();
      run_op("overflow", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0, 27, 0);
      run_op("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 27, 0);
      run_op("neg_overflow", 32'hFF00_0000, 32'h0080_0000, 32'hFF80_0000, 1'b0, 27, 0);
   endtask

   task automatic test_ignored_start();
      run_op("start_while_busy", 32'h40C0_0000, 32'h4080_0000, 32'h3FC0_0000, 1'b0, 27, 10);
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (bus.q !== 32'h3FC0_0000 || bus.dz !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL hold after done: q=%h dz=%b busy=%b required 3fc00000 0 0",
                  bus.q, bus.dz, bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      bit stray;
      bus.x     = 32'h40C0_0000;
      bus.y     = 32'h4080_0000;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid divide busy: got %b required 1", bus.busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.q !== 32'd0 || bus.dz !== 1'b0) begin
         errors++;
         $display("FAIL mid reset outputs: busy=%b done=%b q=%h dz=%b required 0 0 00000000 0",
                  bus.busy, bus.done, bus.q, bus.dz);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stray = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            stray = 1'b1;
      end
      checks++;
      if (stray) begin
         errors++;
         $display("FAIL aborted divide activity: done/busy seen after reset, required none");
      end
      run_op("after_mid_reset", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 27, 0);
   endtask

   task automatic test_back_to_back();
      run_op("b2b_special", 32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1, 0);
      run_op("b2b_normal", 32'h40C0_0000, 32'h4080_0000, 32'h3FC0_0000, 1'b0, 27, 0);
      run_op("b2b_special_after_normal", 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1, 0);
      run_op("b2b_normal_after_special", 32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAA, 1'b0, 27, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.x     = 32'd0;
      bus.y     = 32'd0;
      test_reset();
      test_normal();
      test_special();
      test_range();
      test_ignored_start();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have ports x and y, input, 32 bits each: IEEE-754 single dividend and divisor; captured on the accepting edge.
REQ-005 SHALL have port busy, output, 1 bit: high from the accepting edge until the edge on which done rises.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse; q is valid from this cycle on.
REQ-007 SHALL have port q, output, 32 bits: quotient x/y; held until the next accepted start.
REQ-008 SHALL have port dz, output, 1 bit: divide-by-zero flag; updated with q and held with q.

Function
REQ-009 SHALL use FSM states IDLE, DIVIDE, NORM, DONE; DONE lasts one cycle, then returns to IDLE.
REQ-010 SHALL accept start only in IDLE; start during DIVIDE, NORM or DONE is ignored and has no effect.
REQ-011 SHALL treat exponent field 0 as zero (denormals flushed) and exponent field 255 as Inf/NaN.
REQ-012 SHALL compute the sign as x[31] XOR y[31] for all results except NaN.
REQ-013 SHALL handle special cases by going IDLE->DONE, with done rising one edge after acceptance:
  - any operand exponent 255: q=0x7FC00000, dz=0
  - x zero and y zero: q=0x7FC00000, dz=0
  - y zero, x nonzero: q={sign,0x7F800000[30:0]}, dz=1
  - x zero, y nonzero: q={sign,31'b0}, dz=0
REQ-014 SHALL handle normal operands by going to DIVIDE for exactly 25 cycles; each cycle is one restoring-division step of {1,mx} by {1,my}, producing quotient bits Q[24:0], MSB first.
REQ-015 SHALL complete the normal path in NORM:
  - Q[24]=1: mantissa=Q[23:1], exponent=ex-ey+127
  - Q[24]=0: mantissa=Q[22:0], exponent=ex-ey+126
  - truncation only, no rounding
REQ-016 SHALL evaluate the exponent as a 10-bit signed value:
  - >=255: q={sign,0x7F800000[30:0]}
  - <=0: q={sign,31'b0}
  - dz=0 in both cases
REQ-017 SHALL give the normal path a latency of done rising 27 edges after the accepting edge; busy is high for 26 cycles.
REQ-018 SHALL allow a new start in the cycle after done, with no bubble beyond IDLE.

Reset
REQ-019 SHALL, on rst_n low at any time including mid-division, immediately force state=IDLE and busy=0, done=0, q=0, dz=0, and clear the partial remainder and quotient.
REQ-020 SHALL, after rst_n is released, accept no start until the first rising edge with rst_n high.

Structure
REQ-021 SHALL place the following in a shared package fp_pkg: BIAS=127, EXP_MAX=255, QNAN=0x7FC00000, POS_INF=0x7F800000, and the FSM state enum.
REQ-022 SHALL implement the iterative mantissa divide (remainder register, quotient shift register, step counter) in one sub-module, fp_mant_div, with load/step/ready signals.
REQ-023 SHALL keep the top level to the FSM, special-case decode, exponent arithmetic and normalization.

Verification
REQ-024 SHALL cover: x=0x40C00000 (6.0), y=0x40800000 (4.0) -> q=0x3FC00000, dz=0, done 27 edges after start.
REQ-025 SHALL cover: x=0x3F800000 (1.0), y=0x40400000 (3.0) -> q=0x3EAAAAAA (truncated), dz=0.
REQ-026 SHALL cover: x=0xC0000000 (-2.0), y=0x00000000 -> q=0xFF800000, dz=1, done 1 edge after start.
REQ-027 SHALL cover: x=0x7F000000, y=0x00800000 -> q=0x7F800000 (overflow); x=0x00800000, y=0x7F000000 -> q=0x00000000 (underflow).
REQ-028 SHALL cover: start pulsed again at cycle 10 of a busy division -> ignored, first result unchanged.
REQ-029 SHALL cover: rst_n low at DIVIDE cycle 12 -> outputs all zero and no done pulse; the next start completes normally.
